// File: rtl/imem_responder_if.sv
// Fetch-side bus bundle for the instruction memory responder:
// request channel (address in) and response channel (word, address, error out).
interface imem_responder_if #(
  parameter int DW = 16
);
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [15:0]   REQ_ADDR;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [DW-1:0] RSP_DATA;
  logic [15:0]   RSP_ADDR;
  logic          RSP_ERR;

  // Fetch unit side: issues requests, consumes responses.
  modport master (
    output REQ_VALID, REQ_ADDR, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ADDR, RSP_ERR
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  REQ_VALID, REQ_ADDR, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ADDR, RSP_ERR
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: one outstanding fetch at a time, a fixed
// number of wait states, then a held response until the fetch side takes it.
// A side-band load port writes program words at any time; a load that hits
// the word being sampled is forwarded into the response (write-first).
module imem_responder #(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  imem_responder_if.slave bus,
  input  logic          LD_EN,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [DW-1:0] LD_DATA,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_RESP
  } state_t;

  // Counter preload: WAIT cycles are spent in S_WAIT counting WAIT-1 down to 0.
  localparam logic [3:0] W_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [15:0]   r_addr;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;
  logic [15:0]   r_rsp_addr;
  logic          r_rsp_err;
  logic          r_busy;

  // Program storage; contents survive reset.
  logic [DW-1:0] r_mem [2**AW];

  logic [AW-1:0] w_word_idx;
  logic          w_out_of_range;
  logic          w_ld_hit;
  logic [DW-1:0] w_sample_data;

  assign w_word_idx     = r_addr[AW-1:0];
  assign w_out_of_range = |(r_addr >> AW);
  assign w_ld_hit       = LD_EN && (LD_ADDR == w_word_idx);
  // A same-cycle load wins over the stored word; out-of-range fetches return zero.
  assign w_sample_data  = w_out_of_range ? '0 :
                          (w_ld_hit ? LD_DATA : r_mem[w_word_idx]);

  assign bus.REQ_READY = r_req_ready;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_DATA  = r_rsp_data;
  assign bus.RSP_ADDR  = r_rsp_addr;
  assign bus.RSP_ERR   = r_rsp_err;
  assign BUSY          = r_busy;

  // Load port write, independent of the fetch state machine.
  always_ff @(posedge CLK) begin
    if (LD_EN) begin
      r_mem[LD_ADDR] <= LD_DATA;
    end
  end

  // Fetch state machine with registered handshake and response outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= 16'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= 16'd0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.REQ_VALID && r_req_ready) begin
            r_addr      <= bus.REQ_ADDR;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (WAIT == 0) begin
              r_state <= S_SAMPLE;
            end else begin
              r_cnt   <= W_LOAD;
              r_state <= S_WAIT;
            end
          end else begin
            // Ready comes up on the first edge after reset release.
            r_req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          r_rsp_data  <= w_sample_data;
          r_rsp_addr  <= r_addr;
          r_rsp_err   <= w_out_of_range;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // Response is held untouched until the fetch side takes it.
          if (bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
